matrix_normalization_stream: RTL
================================

Name: matrix_normalization_stream

Overview:
Streaming successor to the in-place min/max normaliser for the NPU post-processing path. It accepts a ROWS x COLS matrix over a valid/ready input stream and buffers it internally while tracking min and max. It then emits each element rescaled to WIDTH_OUT bits, in row-major order, over a valid/ready output stream with backpressure. Differences from the in-place version:
- Rectangular matrices.
- Runtime signed/unsigned interpretation.
- Configurable output width.
- An end-of-frame marker.

Parameters:
- WIDTH_IN, 16, input element width in bits.
- WIDTH_OUT, 8, output element width in bits (2..16).
- ROWS, 10, matrix rows (>=1).
- COLS, 10, matrix columns (>=1).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  begin a new frame; sampled only in IDLE.
- is_signed  input  1  1 = elements are two's complement, 0 = unsigned; latched on accepted start.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block accepts in_data this cycle.
- in_data  input  WIDTH_IN  input element, row-major order.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  sink accepts out_data this cycle.
- out_data  output  WIDTH_OUT  normalised element.
- out_last  output  1  marks the final element (index ROWS*COLS-1), qualified by out_valid.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse after the last output handshake.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, index=0.
  - in_ready, out_valid, out_last, busy and done = 0; out_data = 0.
  - min/max registers and range = 0.
  - Buffer contents are don't-care.
  - Reset asserted mid-frame aborts the frame immediately; no partial outputs follow.
- State machine:
  - IDLE -> LOAD on start=1. Latch is_signed, index=0.
  - LOAD: in_ready=1. Each handshake (in_valid & in_ready) writes buf[index] and updates min/max.
    - The first element of the frame initialises both min and max, not a compare against stale values.
    - Comparisons use the latched is_signed interpretation.
    - After the handshake at index ROWS*COLS-1: in_ready drops, -> RANGE.
  - RANGE: one cycle. range = max - min, computed in WIDTH_IN+1 bits, always non-negative. index=0, -> EMIT.
  - EMIT: out_valid=1, out_data=f(buf[index]), out_last=(index==ROWS*COLS-1).
    - On out_valid & out_ready: index++.
    - On the last handshake: out_valid=0, -> DONE.
    - While out_ready=0: out_data and out_last are held stable; no values change.
  - DONE: done=1 for exactly one cycle, -> IDLE.
- start outside IDLE is ignored. start and in_valid in the same IDLE cycle: the data is not accepted; in_ready rises the next cycle.
- Arithmetic: diff = x - min in WIDTH_IN+1 bits, unsigned, with sign/zero extension per is_signed.
  - If range != 0: out = floor(diff * (2^WIDTH_OUT - 1) / range). The product is WIDTH_IN+1+WIDTH_OUT bits. The result is always in [0, 2^WIDTH_OUT - 1]; no clamp needed.
  - If range == 0: out = 2^(WIDTH_OUT-1), i.e. 128 for 8 bits.
  - min maps to 0; max maps to 2^WIDTH_OUT - 1.
- Latency:
  - First out_valid is 2 cycles after the final input handshake (RANGE cycle, then EMIT registered).
  - One output per cycle under continuous out_ready.
  - Frame throughput = ROWS*COLS load + 1 + ROWS*COLS emit + 1 done cycles, excluding stalls.

Optional Feature:
- Macro: MATRIX_NORM_ROUND_EN.
- Defined: round to nearest, out = floor((diff * (2^WIDTH_OUT - 1) + floor(range/2)) / range). The numerator gains one bit. The result is still bounded by 2^WIDTH_OUT - 1.
- Undefined: truncating floor division as above. The interface is identical in both builds.

Test Plan:
(All cases use ROWS=COLS=2, WIDTH_IN=16, WIDTH_OUT=8 unless stated.)
1. Signed, no rounding: inputs -100, 0, 50, 155 -> outputs 0, 100, 150, 255. out_last only on the 4th output. done pulses once, 1 cycle after the 4th handshake.
2. Mode dependence: inputs 0xFFFF, 0x0000, 0x8000, 0x0001.
   - is_signed=1 -> outputs 254, 254, 0, 255.
   - is_signed=0 -> outputs 255, 0, 127, 0. With MATRIX_NORM_ROUND_EN, the third output is 128.
3. Constant frame: four inputs of 7 -> four outputs of 128; no divide performed.
4. Backpressure and stalls:
   - out_ready held low 3 cycles on the 2nd output -> out_data and out_last stable, index unchanged; the remaining outputs follow in order.
   - in_valid gaps during LOAD -> results identical to case 1.
5. Reset abort: reset pulsed low after 2 input handshakes -> all outputs 0 and state IDLE immediately. A following full frame reproduces case 1 exactly (no stale min/max).
6. Ignored start: start asserted during LOAD and EMIT -> no effect. ROWS=3, COLS=1, inputs 10, 20, 30 -> outputs 0, 127, 255.

Source files
------------

// File: rtl/matrix_normalization_stream.sv
// Streaming min/max normaliser: buffers a ROWS x COLS frame, then emits each element rescaled to WIDTH_OUT bits.
// Optional build macro MATRIX_NORM_ROUND_EN selects round-to-nearest instead of truncating division.
//
// state | meaning
// IDLE  | waiting for start
// LOAD  | accepting input elements, tracking min/max
// RANGE | one cycle: range = max - min, first output prepared
// EMIT  | presenting normalised elements with backpressure
// DONE  | one-cycle completion pulse
module matrix_normalization_stream #(
  parameter int WIDTH_IN  = 16,
  parameter int WIDTH_OUT = 8,
  parameter int ROWS      = 10,
  parameter int COLS      = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 is_signed,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH_IN-1:0]  in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH_OUT-1:0] out_data,
  output logic                 out_last,
  output logic                 busy,
  output logic                 done
);

  localparam int N  = ROWS * COLS;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int DW = WIDTH_IN + 1;
  localparam int PW = DW + WIDTH_OUT;
  localparam int NW = PW + 1;
  localparam logic [IW-1:0]        LAST  = IW'(N - 1);
  localparam logic [PW-1:0]        SCALE = PW'((2 ** WIDTH_OUT) - 1);
  localparam logic [WIDTH_OUT-1:0] MID   = WIDTH_OUT'(2 ** (WIDTH_OUT - 1));

  typedef enum logic [2:0] {IDLE, LOAD, RANGE, EMIT, DONE} state_t;

  state_t state, state_nxt;

  logic [WIDTH_IN-1:0]  mem [N];
  logic [IW-1:0]        index, index_inc, rd_idx;
  logic                 sgn_q;
  logic [DW-1:0]        min_q, max_q, range_q, range_w, rng_sel;
  logic [DW-1:0]        in_ext, rd_ext, diff;
  logic [PW-1:0]        prod;
  logic [NW-1:0]        num, den;
  logic [WIDTH_OUT-1:0] norm;
  logic                 hs_in, hs_out;

  function automatic logic [DW-1:0] ext(input logic [WIDTH_IN-1:0] x, input logic s);
    return s ? {x[WIDTH_IN-1], x} : {1'b0, x};
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = LOAD;
      LOAD:    if (hs_in && index == LAST) state_nxt = RANGE;
      RANGE:   state_nxt = EMIT;
      EMIT:    if (hs_out && index == LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign in_ready  = (state == LOAD);
  assign out_valid = (state == EMIT);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign hs_in     = in_valid & in_ready;
  assign hs_out    = out_valid & out_ready;

  // Read port looks one element ahead so out_data is registered with the handshake.
  assign index_inc = index + IW'(1);
  assign rd_idx    = (state == EMIT && index != LAST) ? index_inc : '0;
  assign in_ext    = ext(in_data, sgn_q);
  assign rd_ext    = ext(mem[rd_idx], sgn_q);
  assign range_w   = max_q - min_q;
  assign rng_sel   = (state == RANGE) ? range_w : range_q;
  assign diff      = rd_ext - min_q;
  assign prod      = PW'(diff) * SCALE;

  always_comb begin
`ifdef MATRIX_NORM_ROUND_EN
    num = {1'b0, prod} + NW'(rng_sel >> 1);
`else
    num = {1'b0, prod};
`endif
    den  = (rng_sel == '0) ? NW'(1) : NW'(rng_sel);
    norm = (rng_sel == '0) ? MID : WIDTH_OUT'(num / den);
  end

  always_ff @(posedge clk) begin
    if (hs_in) mem[index] <= in_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      index    <= '0;
      sgn_q    <= 1'b0;
      min_q    <= '0;
      max_q    <= '0;
      range_q  <= '0;
      out_data <= '0;
      out_last <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          sgn_q <= is_signed;
          index <= '0;
        end
        LOAD: if (hs_in) begin
          // Element 0 seeds both extremes so nothing from a previous frame leaks in.
          if (index == '0 || $signed(in_ext) < $signed(min_q)) min_q <= in_ext;
          if (index == '0 || $signed(in_ext) > $signed(max_q)) max_q <= in_ext;
          index <= (index == LAST) ? '0 : index_inc;
        end
        RANGE: begin
          range_q  <= range_w;
          index    <= '0;
          out_data <= norm;
          out_last <= (LAST == '0);
        end
        EMIT: if (hs_out) begin
          if (index == LAST) begin
            out_data <= '0;
            out_last <= 1'b0;
          end else begin
            index    <= index_inc;
            out_data <= norm;
            out_last <= (index_inc == LAST);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
